// File: rtl/bit_select_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bit_select_seq_pkg
// Description : Shared definitions for the select unit: FSM state encoding
//               and the derived widths for the default configuration
//               (64-bit operand scanned 8 bits per cycle).
// Revision    : 1.0  initial release
// ============================================================================
package bit_select_seq_pkg;

  localparam int WIDTH_DEF = 64;
  localparam int CHUNK_DEF = 8;

  localparam int IDXW   = $clog2(WIDTH_DEF);
  localparam int NCHUNK = WIDTH_DEF / CHUNK_DEF;
  localparam int CNTW   = $clog2(CHUNK_DEF) + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/bit_select_seq_select_chunk.sv
`default_nettype none
// ============================================================================
// Module      : select_chunk
// Description : Combinational per-chunk select. Counts the ones in a chunk
//               and, if the remaining index falls inside it, reports the
//               in-chunk position of that set bit.
// Ports       : bits   - chunk of the operand (LSB first)
//               r      - remaining index, truncated to CNTW bits
//               r_ovf  - remaining index is >= CHUNK (cannot hit here)
//               cnt    - number of ones in the chunk
//               hit    - target bit lies in this chunk
//               pos    - in-chunk position of the target bit (valid on hit)
// Revision    : 1.0  initial release
// ============================================================================
module select_chunk #(
  parameter int CHUNK = 8,
  parameter int CNTW  = $clog2(CHUNK) + 1
) (
  input  logic [CHUNK-1:0] bits,
  input  logic [CNTW-1:0]  r,
  input  logic             r_ovf,
  output logic [CNTW-1:0]  cnt,
  output logic             hit,
  output logic [CNTW-2:0]  pos
);

  localparam int POSW = CNTW - 1;

  logic [CNTW-1:0] w_run;

  // Prefix count: w_run holds the number of ones strictly below bit i when
  // bit i is examined, so bit i is the r-th set bit exactly when it is set
  // and that prefix equals r. At most one bit can satisfy this.
  always_comb begin
    w_run = '0;
    pos   = '0;
    for (int i = 0; i < CHUNK; i++) begin
      if (bits[i] && (w_run == r)) begin
        pos = POSW'(i);
      end
      w_run = w_run + CNTW'(bits[i]);
    end
    cnt = w_run;
  end

  // The truncated index is only meaningful when no overflow is flagged.
  assign hit = !r_ovf && (r < cnt);

endmodule
`default_nettype wire

// File: rtl/bit_select_seq.sv
`default_nettype none
// ============================================================================
// Module      : bit_select_seq
// Description : Iterative select unit (inverse of popcount). Returns the
//               position of the K-th set bit of A counting from the LSB,
//               scanning CHUNK bits per cycle with early exit on a hit.
// Ports       : clk, reset_n        - clock, async active-low reset
//               FlushE               - synchronous abort of any operation
//               Start / Ready        - request handshake (A, K sampled)
//               ResValid / ResReady  - result handshake
//               Pos, Found, TotalCnt - result, stable while ResValid=1
// Revision    : 1.0  initial release
// ============================================================================
module bit_select_seq
  import bit_select_seq_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CHUNK = CHUNK_DEF
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     FlushE,
  input  logic                     Start,
  output logic                     Ready,
  input  logic [WIDTH-1:0]         A,
  input  logic [$clog2(WIDTH)-1:0] K,
  output logic                     ResValid,
  input  logic                     ResReady,
  output logic [$clog2(WIDTH)-1:0] Pos,
  output logic                     Found,
  output logic [$clog2(WIDTH):0]   TotalCnt
);

  localparam int IDX_W   = $clog2(WIDTH);
  localparam int N_CHUNK = WIDTH / CHUNK;
  localparam int CNT_W   = $clog2(CHUNK) + 1;
  localparam int POS_W   = CNT_W - 1;
  localparam int C_W     = (N_CHUNK > 1) ? $clog2(N_CHUNK) : 1;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;      // operand, shifted down one chunk per miss
  logic [IDX_W-1:0] r_rem;    // remaining index R
  logic [C_W-1:0]   r_c;      // current chunk index C
  logic [IDX_W:0]   r_n;      // ones counted in chunks already passed

  logic [CNT_W-1:0] w_cnt;
  logic             w_hit;
  logic [POS_W-1:0] w_inpos;
  logic [CNT_W-1:0] w_r_trunc;
  logic             w_r_ovf;
  logic             w_last;
  logic [IDX_W:0]   w_total;
  logic [IDX_W-1:0] w_pos;

  // Size cast covers both CHUNK < WIDTH (truncate) and CHUNK == WIDTH
  // (zero-extend); the overflow flag keeps a truncated index from hitting.
  assign w_r_trunc = CNT_W'(r_rem);
  assign w_r_ovf   = (int'(r_rem) >= CHUNK);
  assign w_last    = (int'(r_c) == N_CHUNK - 1);
  assign w_total   = r_n + (IDX_W + 1)'(w_cnt);
  assign w_pos     = IDX_W'(int'(r_c) * CHUNK) + IDX_W'(w_inpos);

  select_chunk #(
    .CHUNK (CHUNK),
    .CNTW  (CNT_W)
  ) u_select_chunk (
    .bits  (r_a[CHUNK-1:0]),
    .r     (w_r_trunc),
    .r_ovf (w_r_ovf),
    .cnt   (w_cnt),
    .hit   (w_hit),
    .pos   (w_inpos)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state  <= ST_IDLE;
      r_a      <= '0;
      r_rem    <= '0;
      r_c      <= '0;
      r_n      <= '0;
      Ready    <= 1'b1;
      ResValid <= 1'b0;
      Pos      <= '0;
      Found    <= 1'b0;
      TotalCnt <= '0;
    end else if (FlushE) begin
      // Abort wins over every transition, including an accept in IDLE.
      r_state  <= ST_IDLE;
      Ready    <= 1'b1;
      ResValid <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_a     <= A;
            r_rem   <= K;
            r_c     <= '0;
            r_n     <= '0;
            Ready   <= 1'b0;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (w_hit) begin
            Pos      <= w_pos;
            Found    <= 1'b1;
            TotalCnt <= w_total;
            ResValid <= 1'b1;
            r_state  <= ST_DONE;
          end else if (w_last) begin
            Pos      <= '0;
            Found    <= 1'b0;
            TotalCnt <= w_total;
            ResValid <= 1'b1;
            r_state  <= ST_DONE;
          end else begin
            // Miss guarantees r_rem >= w_cnt, so no underflow.
            r_rem <= r_rem - IDX_W'(w_cnt);
            r_n   <= w_total;
            r_c   <= r_c + 1'b1;
            r_a   <= r_a >> CHUNK;
          end
        end
        ST_DONE: begin
          if (ResReady) begin
            ResValid <= 1'b0;
            Ready    <= 1'b1;
            r_state  <= ST_IDLE;
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          Ready    <= 1'b1;
          ResValid <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bit_select_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_bit_select_seq
// Description : Self-checking bench for bit_select_seq (WIDTH=64, CHUNK=8).
//               Expected results come from a queue-based model of the
//               select operation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_bit_select_seq;
  import bit_select_seq_pkg::*;

  localparam int WIDTH = 64;
  localparam int CHUNK = 8;
  localparam int NCH   = WIDTH / CHUNK;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            FlushE;
  logic            Start;
  logic            Ready;
  logic [WIDTH-1:0] A;
  logic [IDXW-1:0] K;
  logic            ResValid;
  logic            ResReady;
  logic [IDXW-1:0] Pos;
  logic            Found;
  logic [IDXW:0]   TotalCnt;

  int checks   = 0;
  int failures = 0;

  bit_select_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .FlushE   (FlushE),
    .Start    (Start),
    .Ready    (Ready),
    .A        (A),
    .K        (K),
    .ResValid (ResValid),
    .ResReady (ResReady),
    .Pos      (Pos),
    .Found    (Found),
    .TotalCnt (TotalCnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: list the set-bit positions, pick the k-th; the scan stops
  // in the chunk holding it (or after the last chunk on a miss).
  function automatic void model(input logic [WIDTH-1:0] a, input int k,
                                output int pos, output bit found,
                                output int total, output int lat);
    int q[$];
    int j;
    for (int i = 0; i < WIDTH; i++) if (a[i]) q.push_back(i);
    if (k < q.size()) begin
      pos   = q[k];
      found = 1'b1;
      j     = pos / CHUNK;
      total = 0;
      foreach (q[m]) if (q[m] < (j + 1) * CHUNK) total++;
      lat   = 2 + j;
    end else begin
      pos   = 0;
      found = 1'b0;
      total = q.size();
      lat   = 1 + NCH;
    end
  endfunction

  task automatic run_op(input logic [WIDTH-1:0] a, input int k, input int hold,
                        input string name);
    int  e_pos, e_tot, e_lat, n;
    bit  e_fnd;
    model(a, k, e_pos, e_fnd, e_tot, e_lat);
    n = 0;
    while (Ready !== 1'b1 && n < 20) begin tick(); n++; end
    checks++;
    if (Ready !== 1'b1) begin
      failures++;
      $display("FAIL %s ready_before_accept got=%b want=1", name, Ready);
    end
    A = a; K = IDXW'(k); Start = 1'b1;
    tick();
    Start = 1'b0;
    n = 1;
    while (ResValid !== 1'b1 && n < 100) begin tick(); n++; end
    checks++;
    if (n !== e_lat) begin
      failures++;
      $display("FAIL %s latency got=%0d want=%0d (A=%h K=%0d)", name, n, e_lat, a, k);
    end
    for (int h = 0; h <= hold; h++) begin
      checks++;
      if (ResValid !== 1'b1 || Pos !== IDXW'(e_pos) || Found !== e_fnd ||
          TotalCnt !== (IDXW+1)'(e_tot)) begin
        failures++;
        $display("FAIL %s result got=v%b p%0d f%b t%0d want=v1 p%0d f%b t%0d (A=%h K=%0d)",
                 name, ResValid, Pos, Found, TotalCnt, e_pos, e_fnd, e_tot, a, k);
      end
      if (h < hold) tick();
    end
    ResReady = 1'b1;
    tick();
    ResReady = 1'b0;
    checks++;
    if (ResValid !== 1'b0 || Ready !== 1'b1) begin
      failures++;
      $display("FAIL %s handoff got=v%b r%b want=v0 r1", name, ResValid, Ready);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; FlushE = 1'b0; Start = 1'b0; ResReady = 1'b0;
    A = '0; K = '0;
    tick(); tick();
    checks++;
    if (Ready !== 1'b1 || ResValid !== 1'b0 || Pos !== '0 || Found !== 1'b0 ||
        TotalCnt !== '0) begin
      failures++;
      $display("FAIL reset_values got=r%b v%b p%0d f%b t%0d want=r1 v0 p0 f0 t0",
               Ready, ResValid, Pos, Found, TotalCnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_directed();
    run_op(64'h1, 0, 0, "lsb");
    run_op(64'h8000_0000_0000_0000, 0, 0, "msb");
    run_op('1, 10, 0, "ones_k10");
    run_op('1, 63, 1, "ones_k63");
    run_op(64'hF0, 4, 0, "miss_f0");
    run_op(64'h0, 0, 0, "zero");
    run_op(64'h0100_0000_0000_0000, 0, 0, "chunk7");
  endtask

  task automatic test_backpressure();
    int n;
    A = 64'h0101_0101_0101_0101; K = 6'd5; Start = 1'b1;
    tick();
    A = 64'h1; K = 6'd0;   // Start stays high: must be ignored
    n = 1;
    while (ResValid !== 1'b1 && n < 100) begin
      checks++;
      if (Ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_scan_ready got=%b want=0", Ready);
      end
      tick(); n++;
    end
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL bp_latency got=%0d want=7", n);
    end
    for (int h = 0; h < 5; h++) begin
      Start = h[0];
      checks++;
      if (ResValid !== 1'b1 || Ready !== 1'b0 || Pos !== 6'd40 || Found !== 1'b1 ||
          TotalCnt !== 7'd6) begin
        failures++;
        $display("FAIL bp_hold got=v%b r%b p%0d f%b t%0d want=v1 r0 p40 f1 t6",
                 ResValid, Ready, Pos, Found, TotalCnt);
      end
      tick();
    end
    Start = 1'b1; ResReady = 1'b1;   // Start during the handoff cycle
    tick();
    ResReady = 1'b0; Start = 1'b0;
    checks++;
    if (Ready !== 1'b1 || ResValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_handoff got=r%b v%b want=r1 v0", Ready, ResValid);
    end
    tick();
    checks++;
    if (Ready !== 1'b1 || ResValid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_extra_accept got=r%b v%b want=r1 v0", Ready, ResValid);
    end
  endtask

  task automatic test_flush();
    A = 64'h8000_0000_0000_0000; K = '0; Start = 1'b1;
    tick();                       // now in T+1
    Start = 1'b0;
    tick();                       // T+2
    tick();                       // T+3
    FlushE = 1'b1;
    tick();                       // T+4
    FlushE = 1'b0;
    checks++;
    if (Ready !== 1'b1 || ResValid !== 1'b0) begin
      failures++;
      $display("FAIL flush_scan got=r%b v%b want=r1 v0", Ready, ResValid);
    end
    for (int h = 0; h < 8; h++) begin
      checks++;
      if (ResValid !== 1'b0) begin
        failures++;
        $display("FAIL flush_no_result got=%b want=0", ResValid);
      end
      tick();
    end
    // Flush in DONE drops the result.
    A = 64'h1; K = '0; Start = 1'b1;
    tick(); Start = 1'b0;
    tick();
    checks++;
    if (ResValid !== 1'b1) begin
      failures++;
      $display("FAIL flush_pre_done got=%b want=1", ResValid);
    end
    FlushE = 1'b1;
    tick();
    FlushE = 1'b0;
    checks++;
    if (ResValid !== 1'b0 || Ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_done got=v%b r%b want=v0 r1", ResValid, Ready);
    end
    // Flush coinciding with Start in IDLE suppresses the accept.
    FlushE = 1'b1; Start = 1'b1;
    tick();
    FlushE = 1'b0; Start = 1'b0;
    checks++;
    if (Ready !== 1'b1) begin
      failures++;
      $display("FAIL flush_start got=%b want=1", Ready);
    end
    tick();
    checks++;
    if (Ready !== 1'b1 || ResValid !== 1'b0) begin
      failures++;
      $display("FAIL flush_start_idle got=r%b v%b want=r1 v0", Ready, ResValid);
    end
  endtask

  task automatic test_async_reset();
    A = 64'h8000_0000_0000_0000; K = '0; Start = 1'b1;
    tick(); Start = 1'b0;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks++;
    if (Ready !== 1'b1 || ResValid !== 1'b0 || Pos !== '0 || Found !== 1'b0 ||
        TotalCnt !== '0) begin
      failures++;
      $display("FAIL async_reset got=r%b v%b p%0d f%b t%0d want=r1 v0 p0 f0 t0",
               Ready, ResValid, Pos, Found, TotalCnt);
    end
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    run_op(64'h10, 0, 0, "after_reset");
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] a;
    int k, pc;
    for (int t = 0; t < 60; t++) begin
      case ($urandom_range(0, 3))
        0: a = {$urandom, $urandom};
        1: a = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
        2: a = {$urandom, $urandom} | {$urandom, $urandom};
        default: a = 64'h1 << $urandom_range(0, 63);
      endcase
      pc = $countones(a);
      if ($urandom_range(0, 1) == 0) k = $urandom_range(0, 63);
      else k = $urandom_range(0, pc);
      if (k > 63) k = 63;
      run_op(a, k, $urandom_range(0, 3), "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
